alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

ID/EX pipeline register sitting directly upstream of the ALU in the RV32 subset core. It accepts decoded instructions over a valid/ready handshake and selects operands (register or immediate). It resolves RAW hazards by forwarding from the two later stages, stalls one cycle on load-use, and enforces legal one-hot aluop encoding. Its registered outputs drive the ALU `aluop`, `data1` and `data2` inputs directly.

## Interface
- WIDTH, 32, datapath width
- REGA, 5, register-address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts this cycle (combinational)
- in_aluop  in  14  {ADD,SLL,SRA,XOR,AND,OR,MUL,MULH,RBUS0,EQ,NE,LT,GE,BBUS0}, bits 13..0
- in_rs1, in_rs2  in  REGA  source register addresses
- in_rs1_data, in_rs2_data  in  WIDTH  register-file read values
- in_imm  in  WIDTH  sign-extended immediate
- in_use_imm  in  1  data2 = imm instead of rs2
- in_rd  in  REGA  destination; in_wen  in  1  writes rd
- mem_wen, mem_rd, mem_data, mem_is_load  in  1/REGA/WIDTH/1  producer one stage ahead
- wb_wen, wb_rd, wb_data  in  1/REGA/WIDTH  producer two stages ahead
- flush  in  1  branch taken; kill wrong-path work
- ex_ready  in  1  EX stage can take the held instruction
- ex_valid  out  1; ex_aluop  out  14; ex_data1, ex_data2, ex_store_data  out  WIDTH
- ex_rd  out  REGA; ex_wen  out  1; ex_illegal  out  1
- hazard_cnt  out  16  load-use stall cycles, saturating

## Operation
- Occupancy: EMPTY (ex_valid=0) / FULL (ex_valid=1).
- Forwarding per source s in {rs1, rs2}, evaluated at capture:
  - mem_wen && mem_rd==s && s!=0 → mem_data.
  - Otherwise wb_wen && wb_rd==s && s!=0 → wb_data.
  - Otherwise the register-file value.
  - x0 is never forwarded.
- Operands:
  - data1 = fwd(rs1).
  - data2 = in_use_imm ? in_imm : fwd(rs2).
  - ex_store_data = fwd(rs2) always.
- Load-use hazard: mem_is_load && mem_wen && mem_rd!=0 && (mem_rd==in_rs1 || (!in_use_imm && mem_rd==in_rs2) || mem_rd==in_rs2 when store). In this block it is asserted when mem_rd matches in_rs1 or in_rs2.
- Legality: in_aluop[13:5] and in_aluop[4:0] must each be exactly one-hot.
  - If not, the stage captures aluop 14'h0021 (RBUS0|BBUS0) and forces ex_wen=0 and ex_illegal=1.
  - rd and data are still captured.
- in_ready = flush | (!hazard && (!ex_valid || ex_ready)).
- Next-state priority: rst > flush > hazard > capture > hold.
  - flush: ex_valid←0. Any input handshaking this cycle is consumed and dropped.
  - hazard (and no flush): if ex_ready or EMPTY, ex_valid←0 (bubble). Otherwise hold. hazard_cnt increments, saturating at 16'hFFFF.
  - capture (in_valid && in_ready): load all ex_* and set ex_valid←1.
  - EX takes without a new input (ex_ready, no capture): ex_valid←0, data held.
  - hold (FULL && !ex_ready): every ex_* output is stable. No re-forwarding, because downstream stalls together.
- While ex_valid=0, ex_wen is forced to 0.

## Timing
- Reset values: ex_valid=0, ex_aluop=14'h0021, ex_data1/ex_data2/ex_store_data=0, ex_rd=0, ex_wen=0, ex_illegal=0, hazard_cnt=0.
- Latency: 1 cycle from handshake to ex_* valid.
- Throughput: 1 instruction per cycle with ex_ready=1 and no hazard.
- Load-use costs exactly one bubble cycle. On the next cycle the load sits in wb and wb_data is forwarded.
- Combinational paths: flush, ex_ready and hazard → in_ready. No combinational path from in_* to ex_*.
- rst mid-operation: pending instruction discarded; outputs take reset values next edge.
- flush and hazard together: flush wins and hazard_cnt does not increment.
- ex_illegal is registered with its instruction and clears on the next capture or bubble.

## Test plan
- Reset, then in_aluop=ADD|BBUS0 (14'h2001), rs1_data=5, in_use_imm=1, imm=-3 → next cycle ex_valid=1, ex_data1=5, ex_data2=32'hFFFF_FFFD, ex_aluop=14'h2001.
- Forwarding: in_rs1=3, mem_wen=1, mem_rd=3, mem_data=0x11, wb_wen=1, wb_rd=3, wb_data=0x22 → ex_data1=0x11. With in_rs1=0 and mem_rd=0 → ex_data1=in_rs1_data.
- Load-use: mem_is_load=1, mem_rd=7, in_rs2=7, in_use_imm=0 → in_ready=0 for one cycle, bubble (ex_valid=0), hazard_cnt=1. Next cycle wb_rd=7, wb_data=0x99 → ex_data2=0x99.
- Backpressure: FULL, ex_ready=0 for 3 cycles with new in_valid → in_ready=0, ex_* unchanged. ex_ready=1 → new instruction captured next edge.
- Illegal: in_aluop=14'h3001 (ADD+SLL) → ex_aluop=14'h0021, ex_illegal=1, ex_wen=0.
- Flush with in_valid=1 and FULL → in_ready=1, next cycle ex_valid=0, ex_wen=0. Assert rst mid-stream → all reset values next cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register feeding the ALU, with operand forwarding,
// a one-bubble load-use stall and one-hot aluop legality enforcement.
module alu_issue_stage #(
   parameter int WIDTH = 32,
   parameter int REGA  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [13:0]      in_aluop,
   input  logic [REGA-1:0]  in_rs1,
   input  logic [REGA-1:0]  in_rs2,
   input  logic [WIDTH-1:0] in_rs1_data,
   input  logic [WIDTH-1:0] in_rs2_data,
   input  logic [WIDTH-1:0] in_imm,
   input  logic             in_use_imm,
   input  logic [REGA-1:0]  in_rd,
   input  logic             in_wen,
   input  logic             mem_wen,
   input  logic [REGA-1:0]  mem_rd,
   input  logic [WIDTH-1:0] mem_data,
   input  logic             mem_is_load,
   input  logic             wb_wen,
   input  logic [REGA-1:0]  wb_rd,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             flush,
   input  logic             ex_ready,
   output logic             ex_valid,
   output logic [13:0]      ex_aluop,
   output logic [WIDTH-1:0] ex_data1,
   output logic [WIDTH-1:0] ex_data2,
   output logic [WIDTH-1:0] ex_store_data,
   output logic [REGA-1:0]  ex_rd,
   output logic             ex_wen,
   output logic             ex_illegal,
   output logic [15:0]      hazard_cnt
);
   logic             hazard, cap, legal, wen_q;
   logic [WIDTH-1:0] fwd1, fwd2;
   // mem is the younger producer, so it wins over wb; x0 always reads the regfile
   assign fwd1 = (mem_wen && mem_rd == in_rs1 && in_rs1 != '0) ? mem_data :
                 (wb_wen && wb_rd == in_rs1 && in_rs1 != '0) ? wb_data : in_rs1_data;
   assign fwd2 = (mem_wen && mem_rd == in_rs2 && in_rs2 != '0) ? mem_data :
                 (wb_wen && wb_rd == in_rs2 && in_rs2 != '0) ? wb_data : in_rs2_data;
   assign hazard = in_valid && mem_is_load && mem_wen && mem_rd != '0 &&
                   (mem_rd == in_rs1 || mem_rd == in_rs2);
   assign in_ready = flush || (!hazard && (!ex_valid || ex_ready));
   assign cap = in_valid && in_ready && !flush;
   assign legal = $onehot(in_aluop[13:5]) && $onehot(in_aluop[4:0]);
   assign ex_wen = ex_valid && wen_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_aluop      <= 14'h0021;
         ex_data1      <= '0;
         ex_data2      <= '0;
         ex_store_data <= '0;
         ex_rd         <= '0;
         wen_q         <= 1'b0;
         ex_illegal    <= 1'b0;
         hazard_cnt    <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (hazard) begin
         if (ex_ready || !ex_valid) begin
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
         end
         if (hazard_cnt != 16'hFFFF) hazard_cnt <= hazard_cnt + 16'd1;
      end else if (cap) begin
         ex_valid      <= 1'b1;
         ex_aluop      <= legal ? in_aluop : 14'h0021;
         ex_data1      <= fwd1;
         ex_data2      <= in_use_imm ? in_imm : fwd2;
         ex_store_data <= fwd2;
         ex_rd         <= in_rd;
         wen_q         <= in_wen && legal;
         ex_illegal    <= !legal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: vector table, directed corner sequences and a random run
// checked against a cycle-level behavioural model of the issue stage.
module tb_alu_issue_stage;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_use_imm, in_wen;
   logic [13:0] in_aluop;
   logic [4:0]  in_rs1, in_rs2, in_rd, mem_rd, wb_rd, ex_rd;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, mem_data, wb_data;
   logic        mem_wen, mem_is_load, wb_wen, flush, ex_ready;
   logic        ex_valid, ex_wen, ex_illegal;
   logic [13:0] ex_aluop;
   logic [31:0] ex_data1, ex_data2, ex_store_data;
   logic [15:0] hazard_cnt;
   always #5 clk = ~clk;
   alu_issue_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_aluop(in_aluop), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wen(in_wen),
      .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data), .mem_is_load(mem_is_load),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
      .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_data1(ex_data1), .ex_data2(ex_data2),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_wen(ex_wen),
      .ex_illegal(ex_illegal), .hazard_cnt(hazard_cnt)
   );
   int n_tests = 0, n_fail = 0;
   bit          m_valid, m_wen, m_ill;
   logic [13:0] m_aluop;
   logic [31:0] m_d1, m_d2, m_sd;
   logic [4:0]  m_rd;
   int          m_cnt;
   typedef struct {
      logic [13:0] op;
      logic [4:0]  rs1, rs2;
      logic [31:0] d1, d2, imm;
      logic        ui, wen, mw;
      logic [4:0]  mrd;
      logic [31:0] md;
      logic        ww;
      logic [4:0]  wrd;
      logic [31:0] wd;
      logic [13:0] e_op;
      logic [31:0] e_d1, e_d2, e_sd;
      logic        e_wen, e_ill;
   } vec_t;
   vec_t vt [9];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] rf);
      if (s != 5'd0 && mem_wen && mem_rd == s) return mem_data;
      if (s != 5'd0 && wb_wen && wb_rd == s) return wb_data;
      return rf;
   endfunction
   // One clock: predict in_ready and the next registered state, then compare.
   task automatic tick();
      bit hz, rdy, legal;
      hz = in_valid && mem_is_load && mem_wen && mem_rd != 5'd0 &&
           (mem_rd == in_rs1 || mem_rd == in_rs2);
      rdy = flush || (!hz && (!m_valid || ex_ready));
      legal = $countones(in_aluop[13:5]) == 1 && $countones(in_aluop[4:0]) == 1;
      #1 chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      if (rst) begin
         m_valid = 0; m_wen = 0; m_ill = 0; m_cnt = 0; m_aluop = 14'h0021;
         m_d1 = 0; m_d2 = 0; m_sd = 0; m_rd = 0;
      end else if (flush) m_valid = 0;
      else if (hz) begin
         if (ex_ready || !m_valid) begin m_valid = 0; m_ill = 0; end
         if (m_cnt < 65535) m_cnt++;
      end else if (in_valid && rdy) begin
         m_valid = 1;
         m_aluop = legal ? in_aluop : 14'h0021;
         m_d1 = fwd(in_rs1, in_rs1_data);
         m_sd = fwd(in_rs2, in_rs2_data);
         m_d2 = in_use_imm ? in_imm : m_sd;
         m_rd = in_rd;
         m_wen = in_wen && legal;
         m_ill = !legal;
      end else if (ex_ready) m_valid = 0;
      @(posedge clk);
      #1;
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      chk("ex_wen", {31'd0, ex_wen}, {31'd0, m_valid && m_wen});
      chk("hazard_cnt", {16'd0, hazard_cnt}, 32'(m_cnt));
      if (m_valid) begin
         chk("ex_aluop", {18'd0, ex_aluop}, {18'd0, m_aluop});
         chk("ex_data1", ex_data1, m_d1);
         chk("ex_data2", ex_data2, m_d2);
         chk("ex_store_data", ex_store_data, m_sd);
         chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
         chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, m_ill});
      end
   endtask
   task automatic idle();
      rst = 0; in_valid = 0; in_aluop = 14'h2001; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0; in_wen = 0;
      mem_wen = 0; mem_rd = 0; mem_data = 0; mem_is_load = 0;
      wb_wen = 0; wb_rd = 0; wb_data = 0; flush = 0; ex_ready = 1;
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
      chk({tag, "_aluop"}, {18'd0, ex_aluop}, 32'h21);
      chk({tag, "_d1"}, ex_data1, 32'd0);
      chk({tag, "_d2"}, ex_data2, 32'd0);
      chk({tag, "_sd"}, ex_store_data, 32'd0);
      chk({tag, "_rd"}, {27'd0, ex_rd}, 32'd0);
      chk({tag, "_wen"}, {31'd0, ex_wen}, 32'd0);
      chk({tag, "_ill"}, {31'd0, ex_illegal}, 32'd0);
      chk({tag, "_cnt"}, {16'd0, hazard_cnt}, 32'd0);
   endtask
   initial begin
      vt[0] = '{14'h2001, 5'd1, 5'd2, 32'h5, 32'h77, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                14'h2001, 32'h5, 32'hFFFF_FFFD, 32'h77, 1'b1, 1'b0};
      vt[1] = '{14'h2001, 5'd3, 5'd4, 32'h33, 32'h44, 32'h0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22,
                14'h2001, 32'h11, 32'h44, 32'h44, 1'b1, 1'b0};
      vt[2] = '{14'h0090, 5'd5, 5'd6, 32'h55, 32'h66, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h11, 1'b1, 5'd5, 32'h22,
                14'h0090, 32'h22, 32'h11, 32'h11, 1'b1, 1'b0};
      vt[3] = '{14'h2001, 5'd0, 5'd0, 32'hAB, 32'hCD, 32'h0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22,
                14'h2001, 32'hAB, 32'hCD, 32'hCD, 1'b1, 1'b0};
      vt[4] = '{14'h3001, 5'd1, 5'd2, 32'h10, 32'h20, 32'h30, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                14'h0021, 32'h10, 32'h30, 32'h20, 1'b0, 1'b1};
      vt[5] = '{14'h2000, 5'd1, 5'd2, 32'h10, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                14'h0021, 32'h10, 32'h20, 32'h20, 1'b0, 1'b1};
      vt[6] = '{14'h0021, 5'd8, 5'd9, 32'h88, 32'h99, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h5A,
                14'h0021, 32'h88, 32'h5A, 32'h5A, 1'b0, 1'b0};
      vt[7] = '{14'h0102, 5'd3, 5'd3, 32'h33, 32'h44, 32'h7, 1'b1, 1'b1, 1'b0, 5'd3, 32'h11, 1'b0, 5'd3, 32'h22,
                14'h0102, 32'h33, 32'h7, 32'h44, 1'b1, 1'b0};
      vt[8] = '{14'h2003, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                14'h0021, 32'h1, 32'h2, 32'h2, 1'b0, 1'b1};
      idle();
      rst = 1;
      tick();
      tick();
      chk_reset("rst");
      rst = 0;
      foreach (vt[i]) begin
         in_valid = 1; in_aluop = vt[i].op; in_rs1 = vt[i].rs1; in_rs2 = vt[i].rs2;
         in_rs1_data = vt[i].d1; in_rs2_data = vt[i].d2; in_imm = vt[i].imm;
         in_use_imm = vt[i].ui; in_wen = vt[i].wen; in_rd = 5'(i + 1);
         mem_wen = vt[i].mw; mem_rd = vt[i].mrd; mem_data = vt[i].md;
         wb_wen = vt[i].ww; wb_rd = vt[i].wrd; wb_data = vt[i].wd;
         tick();
         chk($sformatf("v%0d_aluop", i), {18'd0, ex_aluop}, {18'd0, vt[i].e_op});
         chk($sformatf("v%0d_d1", i), ex_data1, vt[i].e_d1);
         chk($sformatf("v%0d_d2", i), ex_data2, vt[i].e_d2);
         chk($sformatf("v%0d_sd", i), ex_store_data, vt[i].e_sd);
         chk($sformatf("v%0d_wen", i), {31'd0, ex_wen}, {31'd0, vt[i].e_wen});
         chk($sformatf("v%0d_ill", i), {31'd0, ex_illegal}, {31'd0, vt[i].e_ill});
      end
      // load-use: one bubble, then the load value arrives through wb
      idle();
      in_valid = 1; in_rs1 = 1; in_rs2 = 7; in_rs2_data = 32'h70; in_wen = 1;
      mem_is_load = 1; mem_wen = 1; mem_rd = 7; mem_data = 32'hEE;
      #1 chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
      chk("lu_cnt", {16'd0, hazard_cnt}, 32'd1);
      mem_is_load = 0; mem_wen = 0; wb_wen = 1; wb_rd = 7; wb_data = 32'h99;
      #1 chk("lu2_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("lu_valid", {31'd0, ex_valid}, 32'd1);
      chk("lu_d2", ex_data2, 32'h99);
      // backpressure: held instruction must not change
      idle();
      ex_ready = 0; in_valid = 1; in_rs1 = 2; in_rs1_data = 32'hB1; in_use_imm = 1; in_imm = 32'hB2;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
         chk("bp_hold_d2", ex_data2, 32'h99);
         chk("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
      end
      ex_ready = 1;
      tick();
      chk("bp_new_d1", ex_data1, 32'hB1);
      chk("bp_new_d2", ex_data2, 32'hB2);
      // flush while FULL and stalled
      ex_ready = 0; flush = 1; in_wen = 1;
      #1 chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("fl_valid", {31'd0, ex_valid}, 32'd0);
      chk("fl_wen", {31'd0, ex_wen}, 32'd0);
      // flush beats hazard, counter untouched
      in_rs1 = 4; mem_is_load = 1; mem_wen = 1; mem_rd = 4;
      tick();
      chk("fh_cnt", {16'd0, hazard_cnt}, 32'd1);
      idle();
      in_valid = 1; in_wen = 1; in_rs1_data = 32'h1234;
      tick();
      rst = 1;
      tick();
      chk_reset("midrst");
      idle();
      for (int k = 0; k < 400; k++) begin
         in_valid = ($urandom_range(0, 9) < 8);
         in_aluop = ($urandom_range(0, 9) < 8) ?
                    ((14'd1 << $urandom_range(5, 13)) | (14'd1 << $urandom_range(0, 4))) : 14'($urandom);
         in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
         in_rd = 5'($urandom); in_wen = 1'($urandom);
         in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
         in_use_imm = 1'($urandom);
         mem_wen = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
         mem_is_load = ($urandom_range(0, 3) == 0);
         wb_wen = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
         flush = ($urandom_range(0, 9) == 0);
         ex_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
